// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia pixel scheduler.
package julia_pkg;

  localparam int unsigned Q_FRAC = 16;
  localparam int unsigned FIX_W  = 32;

  // Signed Q16.16 fixed-point value
  typedef logic signed [FIX_W-1:0] fixed_t;

  // Roughly 3.0 / 640: spans a 3-unit wide window across a 640-pixel row
  localparam fixed_t DEFAULT_STEP = 32'sh0000_0133;

  // Per-pixel sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ARM     = 3'd2,
    S_WAIT    = 3'd3,
    S_WRITE   = 3'd4,
    S_ADVANCE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/julia_coord_gen.sv
// Raster walker: col/row/linear-address counters and Q16.16 coordinate stepping.
module julia_coord_gen
  import julia_pkg::*;
#(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_advance,
  input  fixed_t            i_x_origin,
  input  fixed_t            i_y_origin,
  input  fixed_t            i_step,
  output fixed_t            o_z_real,
  output fixed_t            o_z_imag,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col_c,
  output logic              o_last_pixel_c
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  fixed_t            r_z_real;
  fixed_t            r_z_imag;
  fixed_t            r_x_origin;
  fixed_t            r_step;
  logic              w_last_row;

  assign o_last_col_c   = (r_col == COL_W'(H_RES - 1));
  assign w_last_row     = (r_row == ROW_W'(V_RES - 1));
  assign o_last_pixel_c = o_last_col_c && w_last_row;

  // Load frame origin, then step right along a row; wrap to next row going down (imag decreases)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_z_real   <= '0;
      r_z_imag   <= '0;
      r_x_origin <= '0;
      r_step     <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_z_real   <= i_x_origin;
      r_z_imag   <= i_y_origin;
      r_x_origin <= i_x_origin;
      r_step     <= i_step;
    end else if (i_advance) begin
      if (!o_last_col_c) begin
        r_col    <= r_col + COL_W'(1);
        r_addr   <= r_addr + ADDR_W'(1);
        r_z_real <= r_z_real + r_step;
      end else if (!w_last_row) begin
        r_col    <= '0;
        r_row    <= r_row + ROW_W'(1);
        r_addr   <= r_addr + ADDR_W'(1);
        r_z_real <= r_x_origin;
        r_z_imag <= r_z_imag - r_step;
      end
    end
  end

  assign o_z_real = r_z_real;
  assign o_z_imag = r_z_imag;
  assign o_addr   = r_addr;

endmodule

// File: rtl/julia_pixel_scheduler.sv
// Frame sequencer: issues one engine start per pixel in raster order and writes
// the captured escape intensity to the frame buffer.
// Optional macro JULIA_SCHED_PERF_EN adds the frame_cycles busy-cycle counter output.
module julia_pixel_scheduler
  import julia_pkg::*;
#(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              frame_start,
  input  logic [31:0]       x_origin,
  input  logic [31:0]       y_origin,
  input  logic [31:0]       step,
  input  logic [31:0]       c_real_in,
  input  logic [31:0]       c_imag_in,
  input  logic              calc_done,
  input  logic [7:0]        calc_intensity,
  output logic              calc_start,
  output logic [31:0]       z_real,
  output logic [31:0]       z_imag,
  output logic [31:0]       real_var,
  output logic [31:0]       imag_var,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
`ifdef JULIA_SCHED_PERF_EN
  ,
  output logic [31:0]       frame_cycles
`endif
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_load;
  logic              w_advance;
  logic              w_timeout;
  logic              w_tmo_hit;
  logic              w_last_col;
  logic              w_last_pixel;
  logic [TMO_W-1:0]  r_tmo;
  logic [7:0]        r_cap;
  logic [31:0]       r_real_var;
  logic [31:0]       r_imag_var;
  logic              r_calc_start;
  logic              r_wr_en;
  logic              r_frame_done;
  logic              r_busy;
  logic              r_timeout_err;
  fixed_t            w_z_real;
  fixed_t            w_z_imag;
  logic [ADDR_W-1:0] w_addr;

  // Last cycle of the shared ARM+WAIT budget
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

  julia_coord_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_coord (
    .i_clk          (CLK),
    .i_rst          (RESET),
    .i_load         (w_load),
    .i_advance      (w_advance),
    .i_x_origin     (x_origin),
    .i_y_origin     (y_origin),
    .i_step         (step),
    .o_z_real       (w_z_real),
    .o_z_imag       (w_z_imag),
    .o_addr         (w_addr),
    .o_last_col_c   (w_last_col),
    .o_last_pixel_c (w_last_pixel)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and control strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_load       = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = S_ARM;
      S_ARM: begin
        if (!calc_done) begin
          w_next_state = S_WAIT;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_WAIT: begin
        if (calc_done) begin
          w_next_state = S_WRITE;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: w_next_state = S_ADVANCE;
      S_ADVANCE: begin
        w_advance = 1'b1;
        if (!w_last_col || !w_last_pixel) w_next_state = S_ISSUE;
        else                              w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered strobes decoded from the state being entered, so they align with it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_calc_start <= 1'b0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_calc_start <= (w_next_state == S_ISSUE);
      r_wr_en      <= (w_next_state == S_WRITE);
      r_frame_done <= (w_next_state == S_DONE);
      r_busy       <= (w_next_state != S_IDLE);
    end
  end

  // Constant latch, timeout counter, first-nonzero intensity capture, sticky error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_real_var    <= '0;
      r_imag_var    <= '0;
      r_tmo         <= '0;
      r_cap         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_real_var    <= c_real_in;
        r_imag_var    <= c_imag_in;
        r_timeout_err <= 1'b0;
      end
      if (r_state == S_ISSUE) begin
        r_cap <= '0;
        r_tmo <= '0;
      end else if ((r_state == S_ARM || r_state == S_WAIT) && !w_tmo_hit) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (r_state == S_WAIT && r_cap == 8'd0 && calc_intensity != 8'd0) begin
        r_cap <= calc_intensity;
      end
      if (w_timeout) begin
        r_cap         <= '0;
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef JULIA_SCHED_PERF_EN
  logic [31:0] r_frame_cycles;

  // Busy-cycle counter: cleared on frame acceptance, frozen once idle
  always_ff @(posedge CLK) begin
    if (RESET)       r_frame_cycles <= '0;
    else if (w_load) r_frame_cycles <= '0;
    else if (r_busy) r_frame_cycles <= r_frame_cycles + 32'd1;
  end

  assign frame_cycles = r_frame_cycles;
`endif

  assign calc_start  = r_calc_start;
  assign z_real      = w_z_real;
  assign z_imag      = w_z_imag;
  assign real_var    = r_real_var;
  assign imag_var    = r_imag_var;
  assign wr_en       = r_wr_en;
  assign wr_addr     = w_addr;
  assign wr_data     = r_cap;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// Directed bench for julia_pixel_scheduler on a 4x2 frame with a behavioural engine.
module tb_julia_pixel_scheduler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        frame_start;
  logic [31:0] x_origin, y_origin, step, c_real_in, c_imag_in;
  logic        calc_done;
  logic [7:0]  calc_intensity;
  logic        calc_start;
  logic [31:0] z_real, z_imag, real_var, imag_var;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, frame_done, timeout_err;
`ifdef JULIA_SCHED_PERF_EN
  logic [31:0] frame_cycles;
`endif

  always #5 CLK = ~CLK;

  julia_pixel_scheduler #(
    .H_RES(4), .V_RES(2), .ADDR_W(3), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .frame_start(frame_start),
    .x_origin(x_origin), .y_origin(y_origin), .step(step),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .calc_done(calc_done), .calc_intensity(calc_intensity),
    .calc_start(calc_start), .z_real(z_real), .z_imag(z_imag),
    .real_var(real_var), .imag_var(imag_var),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
`ifdef JULIA_SCHED_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural engine: done low for 5 cycles after start (or forever when stuck);
  // intensity pulses eng_v1 at count 1 and eng_v2 at count 3 of the busy window.
  logic [7:0] eng_v1 [0:7];
  logic [7:0] eng_v2 [0:7];
  bit         eng_stuck [0:7];
  int         eng_cnt;
  logic [2:0] eng_pix;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) begin
      calc_done <= 1'b1;
      eng_cnt   <= 0;
      eng_pix   <= 3'd0;
    end else if (calc_start) begin
      calc_done <= 1'b0;
      eng_cnt   <= 0;
      eng_pix   <= wr_addr;
    end else if (!calc_done) begin
      eng_cnt <= eng_cnt + 1;
      if (!eng_stuck[eng_pix] && eng_cnt == 4) calc_done <= 1'b1;
    end
  end

  always @* begin
    calc_intensity = 8'h00;
    if (!calc_done && eng_cnt == 1) calc_intensity = eng_v1[eng_pix];
    else if (!calc_done && eng_cnt == 3) calc_intensity = eng_v2[eng_pix];
  end

  // Output log sampled on the falling edge
  logic [2:0]  wr_a [0:15];
  logic [7:0]  wr_d [0:15];
  logic [31:0] zr_log [0:7];
  logic [31:0] zi_log [0:7];
  int          sc [0:7];
  int          wc [0:7];
  int          n_wr = 0;
  int          n_done = 0;

  always @(negedge CLK) begin
    if (wr_en) begin
      if (n_wr < 16) begin
        wr_a[n_wr] = wr_addr;
        wr_d[n_wr] = wr_data;
      end
      n_wr = n_wr + 1;
      wc[wr_addr] = cyc;
    end
    if (frame_done) n_done = n_done + 1;
    if (calc_start) begin
      zr_log[wr_addr] = z_real;
      zi_log[wr_addr] = z_imag;
      sc[wr_addr]     = cyc;
    end
  end

  task automatic engine_default();
    for (int i = 0; i < 8; i++) begin
      eng_v1[i]    = 8'h10 + 8'(i);
      eng_v2[i]    = 8'h00;
      eng_stuck[i] = 1'b0;
    end
  endtask

  task automatic clear_log();
    n_wr   = 0;
    n_done = 0;
  endtask

  task automatic start_frame(input logic [31:0] xo, input logic [31:0] yo, input logic [31:0] st);
    @(negedge CLK);
    x_origin    = xo;
    y_origin    = yo;
    step        = st;
    c_real_in   = 32'hFFFF_4000;
    c_imag_in   = 32'h0000_2000;
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (n_done == 0 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_frame_done_wait: got no frame_done within 2000 cycles, want one", name);
    end
  endtask

  task automatic wait_start(input logic [2:0] a);
    int k;
    k = 0;
    while (!(calc_start && wr_addr == a) && k < 500) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (!(calc_start && wr_addr == a)) begin
      errors++;
      $display("FAIL wait_start: got no calc_start at addr %0d, want one", a);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    frame_start = 1'b0;
    x_origin = '0; y_origin = '0; step = '0; c_real_in = '0; c_imag_in = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, calc_start, wr_en, frame_done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 00000", {busy, calc_start, wr_en, frame_done, timeout_err});
    end
    checks++;
    if ({z_real, z_imag, real_var, imag_var} !== 128'd0) begin
      errors++;
      $display("FAIL reset_coord: got %h %h %h %h, want all 0", z_real, z_imag, real_var, imag_var);
    end
    checks++;
    if ({wr_addr, wr_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_wr: got addr %0d data %h, want 0 0", wr_addr, wr_data);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_raster();
    engine_default();
    clear_log();
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL raster_busy_high: got %b, want 1", busy);
    end
    wait_done("raster");
    @(negedge CLK);
    checks++;
    if (n_wr !== 8) begin
      errors++;
      $display("FAIL raster_write_count: got %0d, want 8", n_wr);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_a[i] !== 3'(i) || wr_d[i] !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL raster_write_%0d: got addr %0d data %h, want addr %0d data %h",
                 i, wr_a[i], wr_d[i], i, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL raster_done: got frame_done count %0d busy %b, want 1 0", n_done, busy);
    end
    checks++;
    if (zr_log[5] !== 32'hFFFE_8000 || zi_log[5] !== 32'h0000_8000) begin
      errors++;
      $display("FAIL raster_pixel5_z: got %h %h, want fffe8000 00008000", zr_log[5], zi_log[5]);
    end
    checks++;
    if (zr_log[0] !== 32'hFFFE_0000 || zi_log[0] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL raster_pixel0_z: got %h %h, want fffe0000 00010000", zr_log[0], zi_log[0]);
    end
    checks++;
    if (zr_log[3] !== 32'hFFFF_8000 || zr_log[4] !== 32'hFFFE_0000 || zi_log[4] !== 32'h0000_8000) begin
      errors++;
      $display("FAIL raster_row_wrap_z: got p3 %h p4 %h/%h, want ffff8000 fffe0000/00008000",
               zr_log[3], zr_log[4], zi_log[4]);
    end
    checks++;
    if (real_var !== 32'hFFFF_4000 || imag_var !== 32'h0000_2000) begin
      errors++;
      $display("FAIL raster_c_latch: got %h %h, want ffff4000 00002000", real_var, imag_var);
    end
    checks++;
    if (wc[0] - sc[0] !== 7 || sc[1] - sc[0] !== 9) begin
      errors++;
      $display("FAIL raster_latency: got start-to-write %0d period %0d, want 7 9",
               wc[0] - sc[0], sc[1] - sc[0]);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL raster_no_timeout: got %b, want 0", timeout_err);
    end
  endtask

  task automatic test_capture();
    engine_default();
    eng_v1[2] = 8'h40;
    eng_v2[2] = 8'h90;
    eng_v1[6] = 8'h00;
    eng_v2[5] = 8'h77;
    clear_log();
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0100);
    wait_done("capture");
    checks++;
    if (wr_d[2] !== 8'h40) begin
      errors++;
      $display("FAIL capture_first_nonzero: got %h, want 40", wr_d[2]);
    end
    checks++;
    if (wr_d[6] !== 8'h00) begin
      errors++;
      $display("FAIL capture_never_nonzero: got %h, want 00", wr_d[6]);
    end
    checks++;
    if (wr_d[5] !== 8'h15) begin
      errors++;
      $display("FAIL capture_keep_first: got %h, want 15", wr_d[5]);
    end
  endtask

  task automatic test_timeout();
    engine_default();
    eng_stuck[3] = 1'b1;
    clear_log();
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0100);
    wait_done("timeout");
    checks++;
    if (n_wr !== 8 || wr_d[3] !== 8'h00 || wr_a[3] !== 3'd3) begin
      errors++;
      $display("FAIL timeout_pixel: got count %0d addr %0d data %h, want 8 3 00", n_wr, wr_a[3], wr_d[3]);
    end
    checks++;
    if (wc[3] - sc[3] !== 17) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles start-to-write, want 17", wc[3] - sc[3]);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_sticky: got %b, want 1", timeout_err);
    end
    checks++;
    if (wr_d[4] !== 8'h14) begin
      errors++;
      $display("FAIL timeout_next_pixel: got %h, want 14", wr_d[4]);
    end
    engine_default();
    clear_log();
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0100);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got %b, want 0", timeout_err);
    end
    wait_done("timeout_clear");
  endtask

  task automatic test_reset_mid_frame();
    int held;
    engine_default();
    clear_log();
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
    wait_start(3'd3);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if ({busy, calc_start, wr_en, frame_done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b, want 00000", {busy, calc_start, wr_en, frame_done, timeout_err});
    end
    checks++;
    if ({z_real, z_imag, real_var, imag_var, wr_addr, wr_data} !== 139'd0) begin
      errors++;
      $display("FAIL midreset_data: got %h %h %h %h %0d %h, want all 0",
               z_real, z_imag, real_var, imag_var, wr_addr, wr_data);
    end
    RESET = 1'b0;
    held = n_wr;
    repeat (40) @(negedge CLK);
    checks++;
    if (held !== 3 || n_wr !== 3 || n_done !== 0) begin
      errors++;
      $display("FAIL midreset_abort: got writes %0d/%0d done %0d, want 3/3 0", held, n_wr, n_done);
    end
    clear_log();
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
    wait_done("midreset_restart");
    checks++;
    if (n_wr !== 8 || wr_a[0] !== 3'd0 || wr_a[7] !== 3'd7) begin
      errors++;
      $display("FAIL midreset_restart: got count %0d first %0d last %0d, want 8 0 7", n_wr, wr_a[0], wr_a[7]);
    end
  endtask

  task automatic test_busy_ignore();
    engine_default();
    clear_log();
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
    wait_start(3'd2);
    x_origin    = 32'h1234_5678;
    y_origin    = 32'h0BAD_0000;
    step        = 32'h0001_0000;
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    wait_done("busy_ignore");
    checks++;
    if (n_wr !== 8 || n_done !== 1) begin
      errors++;
      $display("FAIL busy_ignore_count: got writes %0d done %0d, want 8 1", n_wr, n_done);
    end
    checks++;
    if (zr_log[5] !== 32'hFFFE_8000 || zi_log[5] !== 32'h0000_8000) begin
      errors++;
      $display("FAIL busy_ignore_z: got %h %h, want fffe8000 00008000", zr_log[5], zi_log[5]);
    end
  endtask

  task automatic test_back_to_back();
    engine_default();
    clear_log();
    start_frame(32'h7FFF_8000, 32'h8000_0000, 32'h0000_8000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy %b, want 1", busy);
    end
    wait_done("b2b");
    checks++;
    if (n_wr !== 8 || zr_log[1] !== 32'h8000_0000 || zi_log[4] !== 32'h7FFF_8000) begin
      errors++;
      $display("FAIL b2b_wrap: got count %0d p1 %h p4i %h, want 8 80000000 7fff8000",
               n_wr, zr_log[1], zi_log[4]);
    end
  endtask

  initial begin
    calc_done   = 1'b1;
    frame_start = 1'b0;
    RESET       = 1'b1;
    engine_default();
    test_reset();
    test_raster();
    test_capture();
    test_timeout();
    test_reset_mid_frame();
    test_busy_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
